// File: rtl/phys_reg_free_list_pkg.sv
// Shared free-list constants for the rename, ROB and free-list blocks.
package phys_reg_free_list_pkg;

  localparam int FL_NUM_PHYS_REGS = 64;
  localparam int FL_NUM_ARCH_REGS = 32;
  localparam int PHYS_W           = $clog2(FL_NUM_PHYS_REGS);
  localparam int ARCH_W           = $clog2(FL_NUM_ARCH_REGS);
  localparam int PTR_W            = PHYS_W + 1;
  localparam int RESET_FREE       = FL_NUM_PHYS_REGS - FL_NUM_ARCH_REGS;

endpackage

// File: rtl/phys_reg_free_list_retire_map_table.sv
// Retirement map: arch -> committed phys register, one write port and two
// combinational read ports (commit lookup and recovery read).
module phys_reg_free_list_retire_map_table
  import phys_reg_free_list_pkg::*;
#(
  parameter int NUM_ARCH_REGS = FL_NUM_ARCH_REGS,
  parameter int PW            = PHYS_W,
  parameter int AW            = ARCH_W
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_data,
  input  logic [AW-1:0] lk_addr,
  output logic [PW-1:0] lk_data,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data
);

  logic [PW-1:0] rmap_r [NUM_ARCH_REGS];

  // Map storage: identity mapping out of reset, one commit write per cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        rmap_r[i] <= PW'(i);
      end
    end else if (wr_en) begin
      rmap_r[wr_addr] <= wr_data;
    end
  end

  assign lk_data = rmap_r[lk_addr];
  assign rd_data = rmap_r[rd_addr];

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list with retirement map and one-cycle flush rollback.
// Optional FREELIST_ASSERT_EN builds the sticky commit-protocol checker.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int NUM_PHYS_REGS = FL_NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = FL_NUM_ARCH_REGS
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               alloc_req,
  output logic                               alloc_valid,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]   alloc_reg,
  input  logic                               commit_valid,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0]   commit_arch_reg,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0]   commit_phys_reg,
  input  logic                               FLUSH_IN,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0]   map_arch_rd,
  output logic [$clog2(NUM_PHYS_REGS)-1:0]   map_phys_rd,
  output logic [$clog2(NUM_PHYS_REGS):0]     free_count,
  output logic                               protocol_error
);

  localparam int PW    = $clog2(NUM_PHYS_REGS);
  localparam int AW    = $clog2(NUM_ARCH_REGS);
  localparam int TW    = PW + 1;
  localparam int NFREE = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam logic [TW-1:0] PTR_ONE = TW'(1);

  logic [PW-1:0] fl_r [NUM_PHYS_REGS];
  logic [TW-1:0] spec_head_r, arch_head_r, tail_r;
  logic [TW-1:0] spec_head_nxt_s, arch_head_nxt_s;
  logic          commit_fire_s, alloc_fire_s;
  logic [PW-1:0] rmap_old_s;

  phys_reg_free_list_retire_map_table #(
    .NUM_ARCH_REGS(NUM_ARCH_REGS),
    .PW           (PW),
    .AW           (AW)
  ) u_rmap (
    .CLK    (CLK),
    .RESET  (RESET),
    .wr_en  (commit_fire_s),
    .wr_addr(commit_arch_reg),
    .wr_data(commit_phys_reg),
    .lk_addr(commit_arch_reg),
    .lk_data(rmap_old_s),
    .rd_addr(map_arch_rd),
    .rd_data(map_phys_rd)
  );

  assign free_count    = tail_r - spec_head_r;
  assign alloc_valid   = (free_count != {TW{1'b0}}) && !FLUSH_IN;
  assign alloc_reg     = fl_r[spec_head_r[PW-1:0]];
  assign commit_fire_s = commit_valid && (commit_arch_reg != {AW{1'b0}});
  assign alloc_fire_s  = alloc_req && alloc_valid;

  // Next head pointers; flush restores the post-commit architectural head.
  always_comb begin
    arch_head_nxt_s = arch_head_r;
    spec_head_nxt_s = spec_head_r;
    if (commit_fire_s) begin
      arch_head_nxt_s = arch_head_r + PTR_ONE;
    end else begin
      arch_head_nxt_s = arch_head_r;
    end
    if (FLUSH_IN) begin
      spec_head_nxt_s = arch_head_nxt_s;
    end else if (alloc_fire_s) begin
      spec_head_nxt_s = spec_head_r + PTR_ONE;
    end else begin
      spec_head_nxt_s = spec_head_r;
    end
  end

  // Pointer registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      spec_head_r <= {TW{1'b0}};
      arch_head_r <= {TW{1'b0}};
      tail_r      <= TW'(NFREE);
    end else begin
      spec_head_r <= spec_head_nxt_s;
      arch_head_r <= arch_head_nxt_s;
      if (commit_fire_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
    end
  end

  // Free-list storage; a commit appends the register it displaces from the map.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < NUM_PHYS_REGS; k++) begin
        if (k < NFREE) begin
          fl_r[k] <= PW'(NUM_ARCH_REGS + k);
        end else begin
          fl_r[k] <= {PW{1'b0}};
        end
      end
    end else if (commit_fire_s) begin
      fl_r[tail_r[PW-1:0]] <= rmap_old_s;
    end
  end

`ifdef FREELIST_ASSERT_EN
  logic protocol_error_r;
  logic err_set_s;

  // Commit must retire the oldest outstanding allocation.
  always_comb begin
    err_set_s = 1'b0;
    if (commit_fire_s &&
        ((arch_head_r == spec_head_r) ||
         (commit_phys_reg != fl_r[arch_head_r[PW-1:0]]))) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      protocol_error_r <= 1'b0;
    end else if (err_set_s) begin
      protocol_error_r <= 1'b1;
    end
  end

  assign protocol_error = protocol_error_r;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: table vectors, hand sequences
// and a queue-based free-list scoreboard.
module tb_phys_reg_free_list;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [5:0] alloc_reg;
  logic       commit_valid = 1'b0;
  logic [4:0] commit_arch_reg = 5'd0;
  logic [5:0] commit_phys_reg = 6'd0;
  logic       FLUSH_IN = 1'b0;
  logic [4:0] map_arch_rd = 5'd0;
  logic [5:0] map_phys_rd;
  logic [6:0] free_count;
  logic       protocol_error;

  phys_reg_free_list dut (
    .CLK(CLK), .RESET(RESET), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_reg(alloc_reg), .commit_valid(commit_valid), .commit_arch_reg(commit_arch_reg),
    .commit_phys_reg(commit_phys_reg), .FLUSH_IN(FLUSH_IN), .map_arch_rd(map_arch_rd),
    .map_phys_rd(map_phys_rd), .free_count(free_count), .protocol_error(protocol_error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int m_free[$];
  int m_infl[$];
  int m_rmap[32];
  int exp_perr = 0;
  int last_alloc_reg, last_map;

  typedef struct {
    logic a; logic cv; int arch; int phys; logic fl; int mrd;
    int e_fc; int e_av; int e_reg; int e_map;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_free.delete();
    m_infl.delete();
    for (int k = 0; k < 32; k++) m_free.push_back(32 + k);
    for (int i = 0; i < 32; i++) m_rmap[i] = i;
    exp_perr = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    alloc_req = 1'b0; commit_valid = 1'b0; FLUSH_IN = 1'b0; map_arch_rd = 5'd7;
    RESET = 1'b0;
    #1;
    check("rst_free_count", free_count, 32);
    check("rst_alloc_valid", alloc_valid, 1);
    check("rst_alloc_reg", alloc_reg, 32);
    check("rst_map", map_phys_rd, 7);
    check("rst_protocol_error", protocol_error, 0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // One cycle: drive, compare against scoreboard and optional table targets, advance model.
  task automatic step(input logic a, input logic cv, input int arch, input int phys,
                      input logic fl, input int mrd,
                      input int t_fc, input int t_av, input int t_reg, input int t_map);
    int exp_av;
    int sb;
    @(negedge CLK);
    alloc_req = a; commit_valid = cv; commit_arch_reg = 5'(arch);
    commit_phys_reg = 6'(phys); FLUSH_IN = fl; map_arch_rd = 5'(mrd);
    #1;
    last_alloc_reg = int'(alloc_reg);
    last_map = int'(map_phys_rd);
    exp_av = (m_free.size() != 0 && !fl) ? 1 : 0;
    check("alloc_valid", alloc_valid, exp_av);
    check("free_count", free_count, m_free.size());
    check("map_phys_rd", map_phys_rd, m_rmap[mrd]);
    check("protocol_error", protocol_error, exp_perr);
    if (t_fc >= 0)  check("tbl_free_count", free_count, t_fc);
    if (t_av >= 0)  check("tbl_alloc_valid", alloc_valid, t_av);
    if (t_reg >= 0) check("tbl_alloc_reg", alloc_reg, t_reg);
    if (t_map >= 0) check("tbl_map", map_phys_rd, t_map);
    if (a && exp_av == 1) begin
      sb = m_free.pop_front();
      check("alloc_reg", alloc_reg, sb);
      m_infl.push_back(sb);
    end
    if (cv && arch != 0) begin
      if (m_infl.size() > 0) void'(m_infl.pop_front());
      m_free.push_back(m_rmap[arch]);
      m_rmap[arch] = phys;
    end
    if (fl) begin
      m_free = {m_infl, m_free};
      m_infl.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen[64];
    int distinct;

    // alloc, commit, arch, phys, flush, map rd, free_count, alloc_valid, alloc_reg, map
    vecs[0] = '{1'b1, 1'b0, 0, 0,  1'b0, 0, 32, 1, 32, -1};
    vecs[1] = '{1'b1, 1'b0, 0, 0,  1'b0, 0, 31, 1, 33, -1};
    vecs[2] = '{1'b1, 1'b0, 0, 0,  1'b0, 0, 30, 1, 34, -1};
    vecs[3] = '{1'b0, 1'b1, 1, 32, 1'b0, 0, 29, 1, 35, -1};
    vecs[4] = '{1'b0, 1'b0, 0, 0,  1'b1, 0, 30, 0, -1, -1};
    vecs[5] = '{1'b0, 1'b0, 0, 0,  1'b0, 1, 32, 1, 33, 32};
    vecs[6] = '{1'b1, 1'b0, 0, 0,  1'b0, 0, 32, 1, 33, -1};
    vecs[7] = '{1'b1, 1'b0, 0, 0,  1'b0, 0, 31, 1, 34, -1};
    vecs[8] = '{1'b0, 1'b1, 2, 33, 1'b1, 0, 30, 0, -1, -1};
    vecs[9] = '{1'b0, 1'b0, 0, 0,  1'b0, 2, 32, 1, 34, 33};

    // Flush rollback, including flush coincident with a commit.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].a, vecs[v].cv, vecs[v].arch, vecs[v].phys, vecs[v].fl, vecs[v].mrd,
           vecs[v].e_fc, vecs[v].e_av, vecs[v].e_reg, vecs[v].e_map);
    end

    // Drain the list; the 33rd request is refused and ignored.
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0, 32 - i, 1, 32 + i, -1);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, -1, -1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, -1, -1);

    // Reclaim: the displaced mapping of arch 5 becomes allocatable after the list drains.
    do_reset();
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 32, 1, 32, -1);
    step(1'b0, 1'b1, 5, 40, 1'b0, 0, 31, 1, 33, -1);
`ifdef FREELIST_ASSERT_EN
    exp_perr = 1;
`endif
    step(1'b0, 1'b0, 0, 0, 1'b0, 5, 32, 1, 33, 40);
    for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0, 32 - i, 1, 33 + i, -1);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1, 1, 5, -1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, -1, -1);

    // Long alloc/commit stream wrapping the pointers, then drain and audit.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0, -1, -1, -1, -1);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b1, (i % 31) + 1, m_infl[0], 1'b0, (i % 31) + 1, -1, -1, -1, -1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i % 31) + 1, m_infl[0], 1'b0, 0, -1, -1, -1, -1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 32, 1, -1, -1);
    for (int p = 0; p < 64; p++) seen[p] = 0;
    for (int r = 0; r < 32; r++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0, r, -1, 1, -1, -1);
      seen[last_alloc_reg & 63]++;
      seen[last_map & 63]++;
    end
    distinct = 0;
    for (int p = 0; p < 64; p++) if (seen[p] == 1) distinct++;
    check("unique_regs", distinct, 64);

    // Mixed random traffic with legal in-order commits and occasional flushes.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic cv;
      cv = (m_infl.size() > 0) && ($urandom_range(0, 1) == 1);
      step(1'($urandom_range(0, 1)), cv, int'($urandom_range(1, 31)),
           cv ? m_infl[0] : 0, ($urandom_range(0, 19) == 0), int'($urandom_range(0, 31)),
           -1, -1, -1, -1);
    end

`ifdef FREELIST_ASSERT_EN
    // Commit with nothing outstanding sets the sticky error.
    do_reset();
    step(1'b0, 1'b1, 3, 50, 1'b0, 3, 32, 1, -1, -1);
    exp_perr = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 3, -1, -1, -1, 50);
`endif
    do_reset();
    step(1'b0, 1'b0, 0, 0, 1'b0, 0, 32, 1, 32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
